// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and its neighbours.
// Contents: datapath widths, opcode field position, fetch FSM state
// encoding, reset PC default and a saturating counter helper.
package cpu_pkg;

  localparam int OPCODE_W = 4;
  localparam int INSTR_W  = 16;
  localparam int PC_W     = 8;

  // Opcode occupies the top OPCODE_W bits of an instruction word.
  localparam int OPC_MSB = INSTR_W - 1;
  localparam int OPC_LSB = INSTR_W - OPCODE_W;

  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef enum logic {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

  // 16-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return 16'hFFFF;
    end else begin
      return value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/ready bus.
// Imem_req   : fetch request (master -> slave)
// Imem_addr  : word address of the fetch (master -> slave)
// Imem_ready : slave accepts the request, data valid same cycle
// Imem_data  : instruction word (slave -> master)
interface instruction_fetch_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
);

  logic               Imem_req;
  logic [PC_W-1:0]    Imem_addr;
  logic               Imem_ready;
  logic [INSTR_W-1:0] Imem_data;

  modport master (
    output Imem_req,
    output Imem_addr,
    input  Imem_ready,
    input  Imem_data
  );

  modport slave (
    input  Imem_req,
    input  Imem_addr,
    output Imem_ready,
    output Imem_data
  );

endinterface

// File: rtl/fetch_pc_counter.sv
// Program counter register for the fetch stage.
// Clk/Rst_n    : clock, asynchronous active-low reset (loads RESET_PC)
// load/load_pc : redirect to load_pc (takes priority over inc)
// inc          : advance by one word, wrapping modulo 2^PC_W
// pc           : current program counter
module fetch_pc_counter #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_r;

  // PC register: redirect beats increment; natural overflow gives the wrap.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= load_pc;
    end else if (inc) begin
      pc_r <= pc_r + PC_W'(1);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage feeding the control unit. Fetches one instruction per
// FETCH/ISSUE round trip, registers it, and presents opcode, word and PC.
// Clk, Rst_n     : clock, asynchronous active-low reset
// imem           : instruction memory bus (master side)
// Stall          : downstream cannot take the current instruction (ISSUE only)
// Branch_taken   : redirect to Branch_target, squashing any live/returning word
// Instr/Opcode   : registered instruction and its opcode slice
// Pc_out, Valid  : fetch address of Instr, and Instr is live
// Optional (FETCH_PERF_EN): Fetch_count, Stall_count saturating 16-bit counters.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int                PC_W     = cpu_pkg::PC_W,
  parameter int                INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [PC_W-1:0]   RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  instruction_fetch_if.master  imem,
  input  logic                 Stall,
  input  logic                 Branch_taken,
  input  logic [PC_W-1:0]      Branch_target,
  output logic [INSTR_W-1:0]   Instr,
  output logic [OPCODE_W-1:0]  Opcode,
  output logic [PC_W-1:0]      Pc_out,
`ifdef FETCH_PERF_EN
  output logic [15:0]          Fetch_count,
  output logic [15:0]          Stall_count,
`endif
  output logic                 Valid
);

  fetch_state_e       state_r;
  fetch_state_e       next_state_s;
  logic               req_r;
  logic               valid_r;
  logic [INSTR_W-1:0] instr_r;
  logic [PC_W-1:0]    pc_out_r;
  logic [PC_W-1:0]    pc_s;
  logic               fetch_done_s;

  fetch_pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .load    (Branch_taken),
    .load_pc (Branch_target),
    .inc     (fetch_done_s),
    .pc      (pc_s)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state and fetch completion; a branch overrides everything.
  // Completion needs req_r so the reset-exit cycle (req still low) cannot complete.
  always_comb begin
    next_state_s = state_r;
    fetch_done_s = 1'b0;
    case (state_r)
      FETCH: begin
        if (req_r && imem.Imem_ready && !Branch_taken) begin
          fetch_done_s = 1'b1;
          next_state_s = ISSUE;
        end else begin
          next_state_s = FETCH;
        end
      end
      ISSUE: begin
        if (!Stall) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = ISSUE;
        end
      end
      default: begin
        next_state_s = FETCH;
      end
    endcase
    if (Branch_taken) begin
      next_state_s = FETCH;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // Registered outputs: request tracks the state being entered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      req_r    <= 1'b0;
      valid_r  <= 1'b0;
      instr_r  <= '0;
      pc_out_r <= '0;
    end else begin
      req_r <= (next_state_s == FETCH);
      if (Branch_taken) begin
        valid_r <= 1'b0;
      end else if (fetch_done_s) begin
        valid_r <= 1'b1;
      end else if ((state_r == ISSUE) && !Stall) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      if (fetch_done_s) begin
        instr_r  <= imem.Imem_data;
        pc_out_r <= pc_s;
      end else begin
        instr_r  <= instr_r;
        pc_out_r <= pc_out_r;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_r;
  logic [15:0] stall_count_r;

  // Performance counters: completed fetches and stalled ISSUE cycles.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_count_r <= 16'd0;
      stall_count_r <= 16'd0;
    end else begin
      if (fetch_done_s) begin
        fetch_count_r <= sat_inc16(fetch_count_r);
      end else begin
        fetch_count_r <= fetch_count_r;
      end
      if ((state_r == ISSUE) && Stall) begin
        stall_count_r <= sat_inc16(stall_count_r);
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  assign Fetch_count = fetch_count_r;
  assign Stall_count = stall_count_r;
`endif

  assign imem.Imem_req  = req_r;
  assign imem.Imem_addr = pc_s;
  assign Instr          = instr_r;
  assign Opcode         = instr_r[OPC_MSB:OPC_LSB];
  assign Pc_out         = pc_out_r;
  assign Valid          = valid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed stimulus with a
// scoreboard of expected {pc, instr} pushed at each accepted fetch and
// popped when Valid rises.
module tb_instruction_fetch;

  logic        Clk;
  logic        Rst_n;
  logic        Stall;
  logic        Branch_taken;
  logic [7:0]  Branch_target;
  logic [15:0] Instr;
  logic [3:0]  Opcode;
  logic [7:0]  Pc_out;
  logic        Valid;
`ifdef FETCH_PERF_EN
  logic [15:0] Fetch_count;
  logic [15:0] Stall_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } sb_entry_t;
  sb_entry_t sb[$];

  instruction_fetch_if #(.PC_W(8), .INSTR_W(16)) imem_if ();

  // Instruction memory contents used by the bench.
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    case (a)
      8'h00:   return 16'h1ABC;
      8'h01:   return 16'h3000;
      8'h05:   return 16'hB123;
      8'h10:   return 16'h7E10;
      8'h40:   return 16'h4D40;
      8'hFF:   return 16'hF0FF;
      default: return {a[3:0], 4'h6, a};
    endcase
  endfunction

  assign imem_if.Imem_data = mem_word(imem_if.Imem_addr);

  instruction_fetch dut (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .imem          (imem_if.master),
    .Stall         (Stall),
    .Branch_taken  (Branch_taken),
    .Branch_target (Branch_target),
    .Instr         (Instr),
    .Opcode        (Opcode),
    .Pc_out        (Pc_out),
`ifdef FETCH_PERF_EN
    .Fetch_count   (Fetch_count),
    .Stall_count   (Stall_count),
`endif
    .Valid         (Valid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_fetch(input logic [7:0] a);
    sb_entry_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every rising Valid must match the oldest accepted fetch.
  logic valid_q = 1'b0;
  always @(negedge Clk) begin
    sb_entry_t e;
    if (Valid && !valid_q) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check_eq("sb_instr", 32'(Instr), 32'(e.instr));
        check_eq("sb_pc_out", 32'(Pc_out), 32'(e.pc));
        check_eq("sb_opcode", 32'(Opcode), 32'(e.instr[15:12]));
      end
    end
    valid_q = Valid;
  end

  initial begin
    Rst_n = 1'b0;
    Stall = 1'b0;
    Branch_taken = 1'b0;
    Branch_target = 8'h00;
    imem_if.Imem_ready = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_req", 32'(imem_if.Imem_req), 32'd0);
    check_eq("rst_valid", 32'(Valid), 32'd0);
    check_eq("rst_instr", 32'(Instr), 32'd0);
    check_eq("rst_opcode", 32'(Opcode), 32'd0);
    check_eq("rst_pc_out", 32'(Pc_out), 32'd0);

    // Reset release with zero-wait memory.
    Rst_n = 1'b1;
    step();
    check_eq("first_req", 32'(imem_if.Imem_req), 32'd1);
    check_eq("first_addr", 32'(imem_if.Imem_addr), 32'h00);
    check_eq("first_valid", 32'(Valid), 32'd0);
    imem_if.Imem_ready = 1'b1;
    push_fetch(8'h00);
    step();
    check_eq("issue0_valid", 32'(Valid), 32'd1);
    check_eq("issue0_req", 32'(imem_if.Imem_req), 32'd0);
    check_eq("issue0_opcode", 32'(Opcode), 32'd1);
    step();
    check_eq("fetch1_valid", 32'(Valid), 32'd0);
    check_eq("fetch1_addr", 32'(imem_if.Imem_addr), 32'h01);
    push_fetch(8'h01);
    step();
    check_eq("issue1_opcode", 32'(Opcode), 32'd3);
    imem_if.Imem_ready = 1'b0;
    step();
    check_eq("fetch2_addr", 32'(imem_if.Imem_addr), 32'h02);

    // Wait states at address 0x05.
    Branch_taken = 1'b1;
    Branch_target = 8'h05;
    step();
    Branch_taken = 1'b0;
    check_eq("wait_addr0", 32'(imem_if.Imem_addr), 32'h05);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("wait_addr", 32'(imem_if.Imem_addr), 32'h05);
      check_eq("wait_valid", 32'(Valid), 32'd0);
      check_eq("wait_req", 32'(imem_if.Imem_req), 32'd1);
    end
    imem_if.Imem_ready = 1'b1;
    push_fetch(8'h05);
    step();
    check_eq("wait_done_valid", 32'(Valid), 32'd1);

    // Stall for four ISSUE cycles.
    imem_if.Imem_ready = 1'b0;
    Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("stall_opcode", 32'(Opcode), 32'd11);
      check_eq("stall_valid", 32'(Valid), 32'd1);
      check_eq("stall_req", 32'(imem_if.Imem_req), 32'd0);
    end
    Stall = 1'b0;
    step();
    check_eq("unstall_valid", 32'(Valid), 32'd0);
    check_eq("unstall_req", 32'(imem_if.Imem_req), 32'd1);
    check_eq("unstall_addr", 32'(imem_if.Imem_addr), 32'h06);

    // Branch in the same cycle as a ready fetch at 0x10.
    Branch_taken = 1'b1;
    Branch_target = 8'h10;
    step();
    check_eq("br_setup_addr", 32'(imem_if.Imem_addr), 32'h10);
    imem_if.Imem_ready = 1'b1;
    Branch_target = 8'h40;
    step();
    Branch_taken = 1'b0;
    imem_if.Imem_ready = 1'b0;
    check_eq("br_instr_kept", 32'(Instr), 32'hB123);
    check_eq("br_valid", 32'(Valid), 32'd0);
    check_eq("br_addr", 32'(imem_if.Imem_addr), 32'h40);
    check_eq("br_req", 32'(imem_if.Imem_req), 32'd1);
    imem_if.Imem_ready = 1'b1;
    push_fetch(8'h40);
    step();
    imem_if.Imem_ready = 1'b0;
    check_eq("br_fetch_valid", 32'(Valid), 32'd1);

    // PC wrap from 0xFF, reached by a branch taken in ISSUE.
    Branch_taken = 1'b1;
    Branch_target = 8'hFF;
    step();
    Branch_taken = 1'b0;
    check_eq("wrap_addr_ff", 32'(imem_if.Imem_addr), 32'hFF);
    check_eq("wrap_valid0", 32'(Valid), 32'd0);
    imem_if.Imem_ready = 1'b1;
    push_fetch(8'hFF);
    step();
    imem_if.Imem_ready = 1'b0;
    step();
    check_eq("wrap_addr_00", 32'(imem_if.Imem_addr), 32'h00);
    check_eq("wrap_req", 32'(imem_if.Imem_req), 32'd1);
`ifdef FETCH_PERF_EN
    check_eq("perf_fetch", 32'(Fetch_count), 32'd5);
    check_eq("perf_stall", 32'(Stall_count), 32'd4);
`endif

    // Reset pulse mid-FETCH.
    #2;
    Rst_n = 1'b0;
    #1;
    check_eq("rstf_valid", 32'(Valid), 32'd0);
    check_eq("rstf_req", 32'(imem_if.Imem_req), 32'd0);
    check_eq("rstf_opcode", 32'(Opcode), 32'd0);
`ifdef FETCH_PERF_EN
    check_eq("rstf_fetch_cnt", 32'(Fetch_count), 32'd0);
    check_eq("rstf_stall_cnt", 32'(Stall_count), 32'd0);
`endif
    @(negedge Clk);
    Rst_n = 1'b1;
    step();
    check_eq("rstf_addr", 32'(imem_if.Imem_addr), 32'h00);
    check_eq("rstf_req_back", 32'(imem_if.Imem_req), 32'd1);

    // Reset pulse mid-ISSUE with a stall pending.
    imem_if.Imem_ready = 1'b1;
    push_fetch(8'h00);
    step();
    imem_if.Imem_ready = 1'b0;
    check_eq("rsti_valid_pre", 32'(Valid), 32'd1);
    Stall = 1'b1;
    step();
    #2;
    Rst_n = 1'b0;
    #1;
    check_eq("rsti_valid", 32'(Valid), 32'd0);
    check_eq("rsti_req", 32'(imem_if.Imem_req), 32'd0);
    check_eq("rsti_opcode", 32'(Opcode), 32'd0);
`ifdef FETCH_PERF_EN
    check_eq("rsti_fetch_cnt", 32'(Fetch_count), 32'd0);
    check_eq("rsti_stall_cnt", 32'(Stall_count), 32'd0);
`endif
    @(negedge Clk);
    Rst_n = 1'b1;
    Stall = 1'b0;
    step();
    check_eq("rsti_addr", 32'(imem_if.Imem_addr), 32'h00);
    check_eq("rsti_req_back", 32'(imem_if.Imem_req), 32'd1);

    step();
    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly upstream of the control unit. Holds the program counter, fetches one 16-bit instruction per transaction over a request/ready handshake to instruction memory, and registers it. Presents the 4-bit `Opcode` field, which drives the control unit's `Opcode` input, plus the full instruction and its PC. Downstream stalls hold it; taken branches redirect and squash it.

## Interface
- `PC_W`, 8: program counter / instruction address width (word addressed)
- `INSTR_W`, 16: instruction width; opcode is bits [INSTR_W-1:INSTR_W-4]
- `RESET_PC`, 0: PC value loaded on reset
- `Clk` in 1: clock, rising edge
- `Rst_n` in 1: asynchronous active-low reset
- `Imem_req` out 1: fetch request to instruction memory
- `Imem_addr` out PC_W: fetch address; equals PC while `Imem_req`=1
- `Imem_ready` in 1: memory accepts request; `Imem_data` valid in the same cycle
- `Imem_data` in INSTR_W: instruction word
- `Stall` in 1: downstream cannot consume the current instruction
- `Branch_taken` in 1: redirect request from execute
- `Branch_target` in PC_W: redirect address
- `Instr` out INSTR_W: registered instruction
- `Opcode` out 4: `Instr[INSTR_W-1:INSTR_W-4]`, to control unit
- `Pc_out` out PC_W: address `Instr` was fetched from
- `Valid` out 1: `Instr`/`Opcode`/`Pc_out` hold a live instruction

## Operation
- Reset (async, `Rst_n`=0): PC=RESET_PC, state=FETCH, `Imem_req`=0, `Valid`=0, `Instr`=0 (so `Opcode`=0), `Pc_out`=0.
- `Imem_req` is a registered output: 0 during reset, 1 from the first edge after `Rst_n` rises, whenever state=FETCH.
- FETCH: `Imem_req`=1, `Imem_addr`=PC. At an edge with `Imem_ready`=1, the following happens together: `Instr`<=`Imem_data`, `Pc_out`<=PC, PC<=PC+1, `Valid`<=1, and the state moves to ISSUE. With `Imem_ready`=0, the state holds and `Imem_addr` stays stable.
- ISSUE: `Imem_req`=0, `Valid`=1. With `Stall`=0 at an edge, `Valid`<=0 and the state moves to FETCH. With `Stall`=1, all outputs hold.
- `Stall` is ignored in FETCH.
- Branch: `Branch_taken`=1 at an edge in any state sets PC<=`Branch_target` and `Valid`<=0, and moves the state to FETCH. It has priority over `Imem_ready` and `Stall`. Data returned in that same cycle is discarded and `Instr` is not updated.
- PC increment wraps modulo 2^PC_W: 0xFF+1 gives 0x00 for PC_W=8.
- `Opcode` is a pure slice of the `Instr` register, with no extra logic.
- Reset asserted mid-transaction: the request is dropped immediately and there is no completion.

## Timing
- Every output is registered. `Imem_addr` is the PC register, gated by state for `Imem_req`.
- Fetch latency: `Valid` rises 1 cycle after the edge that samples `Imem_ready`=1.
- Best-case throughput is 1 instruction per 2 cycles: a FETCH cycle plus an ISSUE cycle with zero-wait memory.
- Branch penalty: the cycle after the branch is FETCH at `Branch_target`. `Valid`=0 until that fetch completes.
- `Stall` is sampled only at edges in ISSUE.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `Fetch_count` out 16 and `Stall_count` out 16.
  - `Fetch_count` increments on each completed (non-squashed) fetch.
  - `Stall_count` increments on each ISSUE cycle with `Stall`=1.
  - Both saturate at 0xFFFF and reset to 0.
- `FETCH_PERF_EN` undefined: those ports and their counters are absent. All other behaviour is identical.

## Structure
- Shared package `cpu_pkg`:
  - `OPCODE_W`=4, `INSTR_W`=16, `PC_W`=8
  - opcode field MSB/LSB positions
  - fetch state enum {FETCH, ISSUE}
  - `RESET_PC` default
- One sub-module, `fetch_pc_counter`: the PC register with load (branch), increment (fetch completion), wrap, and async reset. The state machine and instruction register stay in `instruction_fetch`.

## Test plan
- Reset release, memory always ready, `Imem_data`=0x1ABC at addr 0 and 0x3000 at addr 1:
  - `Imem_req`=1, `Imem_addr`=0x00 on the first cycle.
  - Next cycle: `Valid`=1, `Opcode`=1, `Pc_out`=0x00.
  - After ISSUE: `Imem_addr`=0x01; `Opcode`=3 later.
- `Imem_ready` held low 3 cycles in FETCH at addr 0x05:
  - `Imem_addr` stays 0x05 and `Valid` stays 0 throughout.
  - Completion occurs on the 4th cycle.
- `Stall`=1 for 4 cycles in ISSUE with `Instr`=0xB123:
  - `Opcode` stays 11 and `Valid` stays 1; no new request.
  - Fetch resumes 1 cycle after `Stall` drops.
- `Branch_taken`=1, `Branch_target`=0x40, in the same cycle as `Imem_ready`=1 at addr 0x10:
  - `Instr` is unchanged and `Valid`=0.
  - Next `Imem_addr`=0x40.
- PC=0xFF fetch completes -> next `Imem_addr`=0x00.
- `Rst_n` pulsed low mid-FETCH and mid-ISSUE:
  - Immediately `Valid`=0, `Imem_req`=0, `Opcode`=0.
  - After release, `Imem_addr`=RESET_PC.
  - With `FETCH_PERF_EN`, both counters read 0.
